// File: rtl/pov_controller.sv
// -----------------------------------------------------------------------------
// pov_controller
//
// Owns the player point-of-view state (position, facing vector, viewplane
// vector). Per-frame motion from the movement buttons is applied on tick_i.
// Host words arrive over a valid/ready interface into a shadow bank which is
// committed to the active registers in a single edge at the next tick_i, so
// the tracer never sees a half-updated vector set.
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no batch open; first accepted word snapshots active -> shadow
// LOADING | batch open; each accepted word writes one shadow word
// PENDING | batch closed by load_last_i; shadow commits on next tick_i
//
// Ports
//   clk_i           system/pixel clock
//   rst_ni          asynchronous active-low reset
//   tick_i          one-cycle frame-start pulse
//   move_[lrfb]_i   movement buttons (levels, sampled on tick_i only)
//   load_valid_i    host word valid
//   load_ready_o    controller can accept a word (state only)
//   load_sel_i      0 pX, 1 pY, 2 fX, 3 fY, 4 vX, 5 vY, 6-7 none
//   load_data_i     host word value (Q12.12)
//   load_last_i     handshake word closes the batch
//   player_*_o,
//   facing_*_o,
//   vplane_*_o      active registers
//   pending_o       committed batch waiting for tick_i
//   updated_o       one-cycle pulse after the active registers changed
// -----------------------------------------------------------------------------
module pov_controller #(
    parameter int          W       = 24,
    parameter logic [W-1:0] MOVE    = 24'h000050,
    parameter logic [W-1:0] MIN_POS = 24'h001000,
    parameter logic [W-1:0] MAX_POS = 24'h00F000,
    parameter logic [W-1:0] PX0     = 24'h001800,
    parameter logic [W-1:0] PY0     = 24'h00D800,
    parameter logic [W-1:0] FX0     = 24'h000000,
    parameter logic [W-1:0] FY0     = 24'hFFF000,
    parameter logic [W-1:0] VX0     = 24'h000800,
    parameter logic [W-1:0] VY0     = 24'h000000
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         tick_i,
    input  logic         move_l_i,
    input  logic         move_r_i,
    input  logic         move_f_i,
    input  logic         move_b_i,
    input  logic         load_valid_i,
    output logic         load_ready_o,
    input  logic [2:0]   load_sel_i,
    input  logic [W-1:0] load_data_i,
    input  logic         load_last_i,
    output logic [W-1:0] player_x_o,
    output logic [W-1:0] player_y_o,
    output logic [W-1:0] facing_x_o,
    output logic [W-1:0] facing_y_o,
    output logic [W-1:0] vplane_x_o,
    output logic [W-1:0] vplane_y_o,
    output logic         pending_o,
    output logic         updated_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_PENDING = 2'd2
    } state_e;

    localparam int NREG = 6;
    localparam logic [W-1:0] RST_VAL [NREG] = '{PX0, PY0, FX0, FY0, VX0, VY0};

    state_e       state_q, state_d;
    logic         load_hs;
    logic [W-1:0] act_q [NREG];
    logic [W-1:0] act_d [NREG];
    logic [W-1:0] shd_q [NREG];
    logic [W-1:0] shd_d [NREG];
    logic         upd_q, upd_d;
    logic [W-1:0] next_x, next_y;

    // One axis of motion in W+1 signed bits so that stepping past either end
    // of the Q12.12 range cannot wrap before the clamp. An axis with no button
    // pressed holds its value as-is, even if a host load left it out of range.
    function automatic logic [W-1:0] step_pos(input logic [W-1:0] pos,
                                              input logic         dec,
                                              input logic         inc);
        logic signed [W:0] sum;
        logic [W-1:0]      res;
        sum = $signed({pos[W-1], pos});
        if (dec) begin
            sum = sum - $signed({1'b0, MOVE});
        end else if (inc) begin
            sum = sum + $signed({1'b0, MOVE});
        end
        if (sum < $signed({1'b0, MIN_POS})) begin
            res = MIN_POS;
        end else if (sum > $signed({1'b0, MAX_POS})) begin
            res = MAX_POS;
        end else begin
            res = sum[W-1:0];
        end
        if (!dec && !inc) begin
            res = pos;
        end
        return res;
    endfunction

    // ---------------------------------------------------------------- FSM --
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load_hs) begin
                    state_d = load_last_i ? ST_PENDING : ST_LOADING;
                end
            end
            ST_LOADING: begin
                if (load_hs && load_last_i) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (tick_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_ready_o = (state_q != ST_PENDING);
        pending_o    = (state_q == ST_PENDING);
    end

    assign load_hs = load_valid_i && load_ready_o;

    // ------------------------------------------------------------ datapath --
    assign next_x = step_pos(act_q[0], move_l_i, move_r_i);
    assign next_y = step_pos(act_q[1], move_f_i, move_b_i);

    always_comb begin
        shd_d = shd_q;
        act_d = act_q;
        upd_d = 1'b0;

        // The snapshot uses the pre-edge active values; the selected word then
        // overrides its slot in the same edge.
        if (load_hs) begin
            if (state_q == ST_IDLE) begin
                shd_d = act_q;
            end
            if (load_sel_i < 3'(NREG)) begin
                shd_d[load_sel_i] = load_data_i;
            end
        end

        // A word closing a batch on the same edge as tick_i only moves the
        // FSM into PENDING; this tick is still a motion tick.
        if (tick_i) begin
            if (state_q == ST_PENDING) begin
                act_d = shd_q;
                upd_d = 1'b1;
            end else begin
                act_d[0] = next_x;
                act_d[1] = next_y;
                upd_d    = (next_x != act_q[0]) || (next_y != act_q[1]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                act_q[i] <= RST_VAL[i];
                shd_q[i] <= RST_VAL[i];
            end
            upd_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                act_q[i] <= act_d[i];
                shd_q[i] <= shd_d[i];
            end
            upd_q <= upd_d;
        end
    end

    assign player_x_o = act_q[0];
    assign player_y_o = act_q[1];
    assign facing_x_o = act_q[2];
    assign facing_y_o = act_q[3];
    assign vplane_x_o = act_q[4];
    assign vplane_y_o = act_q[5];
    assign updated_o  = upd_q;

endmodule

// File: doc/pov_controller.md
# pov_controller

Owns the player point-of-view state (position, facing vector, viewplane vector) and sequences every update to it. It applies per-frame motion from the movement buttons and accepts host-supplied vectors through a valid/ready word interface into a shadow bank. The shadow bank is committed atomically at a frame `tick`, so the tracer never sees a half-updated vector set during VBLANK.

## Interface
- `W`, 24: fixed-point word width (Q12.12, two's complement).
- `MOVE`, 24'h000050: per-tick motion step (playerWalk, 10×moveQuantum).
- `MIN_POS`, 24'h001000: lower clamp for motion results (1.0).
- `MAX_POS`, 24'h00F000: upper clamp for motion results (15.0).
- `PX0`/`PY0`, 24'h001800 / 24'h00D800: reset position (1.5, 13.5).
- `FX0`/`FY0`, 24'h000000 / 24'hFFF000: reset facing (0, −1).
- `VX0`/`VY0`, 24'h000800 / 24'h000000: reset viewplane (0.5, 0).

Ports:
- `clk`  in  1  system/pixel clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle pulse at frame start (h==0, v==0).
- `moveL`/`moveR`/`moveF`/`moveB`  in  1 each  movement buttons; level, sampled only on `tick`.
- `load_valid`  in  1  host word valid.
- `load_ready`  out  1  controller can accept a word.
- `load_sel`  in  3  target: 0 playerX, 1 playerY, 2 facingX, 3 facingY, 4 vplaneX, 5 vplaneY, 6–7 none.
- `load_data`  in  W  word value.
- `load_last`  in  1  qualifies the handshake word as the final word of a batch.
- `playerX`, `playerY`, `facingX`, `facingY`, `vplaneX`, `vplaneY`  out  W each  active registers.
- `pending`  out  1  a committed batch is waiting for `tick`.
- `updated`  out  1  one-cycle pulse when active registers changed (load or motion).

## Operation
- Handshake: a word transfers on a rising `clk` edge where `load_valid && load_ready`.
- FSM states: IDLE, LOADING, PENDING.
  - IDLE: on handshake, copy all six active registers into the shadow bank, then overwrite the selected shadow word in the same edge. Go to PENDING if `load_last`, otherwise LOADING.
  - LOADING: each handshake writes the selected shadow word. Go to PENDING on `load_last`.
  - PENDING: `load_ready`=0. On `tick`, all six active registers take shadow values in one edge, `updated` pulses, and the FSM returns to IDLE.
- `load_sel` 6/7: the word is accepted (counts for `load_last`) but writes nothing.
- Unwritten shadow words keep their copied active values, so a partial batch leaves the other vectors unchanged.
- Motion applies on `tick` only when the FSM is not in PENDING:
  - `moveL` subtracts MOVE from playerX; `moveR` adds it; L has priority over R.
  - `moveF` subtracts MOVE from playerY; `moveB` adds it; F has priority over B.
  - Each result is computed in W+1 bits (signed) and clamped to [MIN_POS, MAX_POS].
  - Facing and vplane never change by motion.
  - `updated` pulses only if either position value actually changed.
- A commit tick suppresses motion for that frame.
- Host loads are not clamped.
- `pending` = (state==PENDING).
- `load_ready` = (state!=PENDING); combinational from state only, not dependent on `load_valid`.

## Timing
- Reset (asynchronous assert, synchronous release):
  - Active and shadow registers take the `*0` values; state IDLE.
  - `pending`=0, `updated`=0, `load_ready`=1.
- Active registers change only on a `clk` edge where `tick`=1. Outputs are valid the cycle after that edge.
- `updated` is high for exactly the cycle following that edge.
- Last word and `tick` in the same cycle: the word is accepted and the FSM enters PENDING. That tick performs normal motion, not the commit. Commit happens at the next `tick`.
- Commit latency: first `tick` strictly after the `load_last` handshake, i.e. at most one frame.
- A `tick` arriving while in LOADING applies motion and leaves the shadow bank and FSM state untouched.
- `reset_n` asserted mid-batch discards the shadow bank and any pending commit. No partial vectors reach the outputs.
- `load_valid` may be asserted while `load_ready`=0; no transfer occurs, and the host holds its word.

## Test plan
- Reset → playerX=0x001800, playerY=0x00D800, facingY=0xFFF000, vplaneX=0x000800, `load_ready`=1, `pending`=0.
- `moveL`+`moveF` held, one `tick` → playerX=0x0017B0, playerY=0x00D7B0, `updated` pulse. `moveL`+`moveR` together → only L is applied.
- playerX=0x001020, `moveL`, `tick` → playerX=0x001000, clamped. A second `tick` → no change and no `updated`.
- Six-word batch (sel 0..5, last on sel 5) with motion held → `pending`=1 and `load_ready`=0 until `tick`. At `tick`, all six outputs change together to the loaded values, motion is ignored, and `pending` returns to 0.
- One-word batch: sel 2 = 0x001000 with `load_last` → at `tick` only facingX changes; the other five outputs stay unchanged.
- `load_last` coincident with `tick` → motion applied that tick and commit at the next `tick`. Separately, `reset_n` low after 3 words → outputs return to reset values and nothing is committed.
